// File: rtl/hvac_zone_scheduler.sv
// Shared heating/cooling plant scheduler: round-robin mode selection over zone
// requests, fan lead/lag sequencing, minimum on/off times and damper grants.
module hvac_zone_scheduler #(
    parameter int NZONES   = 4,
    parameter int FAN_LEAD = 2,
    parameter int MIN_ON   = 8,
    parameter int MAX_RUN  = 32,
    parameter int FAN_LAG  = 3,
    parameter int MIN_OFF  = 4,
    parameter int CW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NZONES-1:0] heat_req,
    input  logic [NZONES-1:0] cool_req,
    output logic              heat,
    output logic              fan,
    output logic              ac,
    output logic [NZONES-1:0] zone_grant,
    output logic [1:0]        mode
);

    localparam int PW  = (NZONES > 1) ? $clog2(NZONES) : 1;
    localparam int PW1 = PW + 1;

    localparam logic [1:0] M_NONE = 2'b00;
    localparam logic [1:0] M_HEAT = 2'b01;
    localparam logic [1:0] M_COOL = 2'b10;

    // Timer holds cycles already spent in the state, so "N cycles" ends at N-1.
    localparam logic [CW-1:0] LEAD_LAST = CW'(FAN_LEAD - 1);
    localparam logic [CW-1:0] ON_LAST   = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(MAX_RUN - 1);
    localparam logic [CW-1:0] LAG_LAST  = CW'(FAN_LAG - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'(MIN_OFF - 1);
    localparam logic [CW-1:0] T_MAX     = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FAN_LEAD = 3'd1,
        S_RUN      = 3'd2,
        S_FAN_LAG  = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CW-1:0]     timer_r;
    logic [PW-1:0]     rr_ptr_r;
    logic [NZONES-1:0] cool_eff_s;
    logic [NZONES-1:0] mode_req_s;
    logic              in_mode_s;
    logic              opp_s;
    logic              found_s;
    logic              pick_heat_s;
    logic [PW-1:0]     pick_zone_s;
    logic [PW-1:0]     next_ptr_s;
    logic [PW1-1:0]    sum_s;
    logic [PW-1:0]     idx_s;
    logic [1:0]        next_mode_s;
    logic              active_s;

    // Request qualification and round-robin pick starting at rr_ptr.
    always_comb begin
        cool_eff_s  = cool_req & ~heat_req;
        found_s     = 1'b0;
        pick_heat_s = 1'b0;
        pick_zone_s = '0;
        sum_s       = '0;
        idx_s       = '0;
        for (int i = 0; i < NZONES; i++) begin
            sum_s = {1'b0, rr_ptr_r} + PW1'(i);
            if (sum_s >= PW1'(NZONES)) begin
                sum_s = sum_s - PW1'(NZONES);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PW-1:0];
            if (!found_s && (heat_req[idx_s] || cool_eff_s[idx_s])) begin
                found_s     = 1'b1;
                pick_zone_s = idx_s;
                pick_heat_s = heat_req[idx_s];
            end else begin
                found_s = found_s;
            end
        end
        if (pick_zone_s == PW'(NZONES - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = pick_zone_s + PW'(1);
        end
        case (mode)
            M_HEAT: begin
                mode_req_s = heat_req;
                opp_s      = |cool_eff_s;
            end
            M_COOL: begin
                mode_req_s = cool_eff_s;
                opp_s      = |heat_req;
            end
            default: begin
                mode_req_s = '0;
                opp_s      = 1'b0;
            end
        endcase
        in_mode_s = |mode_req_s;
    end

    // Next-state and next-mode decision.
    always_comb begin
        next_state_s = state_r;
        next_mode_s  = mode;
        case (state_r)
            S_IDLE: begin
                if (found_s) begin
                    next_state_s = S_FAN_LEAD;
                    next_mode_s  = pick_heat_s ? M_HEAT : M_COOL;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FAN_LEAD: begin
                if (timer_r >= LEAD_LAST) begin
                    next_state_s = in_mode_s ? S_RUN : S_FAN_LAG;
                end else begin
                    next_state_s = S_FAN_LEAD;
                end
            end
            S_RUN: begin
                if ((timer_r >= ON_LAST) &&
                    (!in_mode_s || ((timer_r >= RUN_LAST) && opp_s))) begin
                    next_state_s = S_FAN_LAG;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_FAN_LAG: begin
                if (timer_r >= LAG_LAST) begin
                    next_state_s = S_LOCKOUT;
                    next_mode_s  = M_NONE;
                end else begin
                    next_state_s = S_FAN_LAG;
                end
            end
            S_LOCKOUT: begin
                next_mode_s = M_NONE;
                if (timer_r >= OFF_LAST) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_LOCKOUT;
                end
            end
            default: begin
                next_state_s = S_IDLE;
                next_mode_s  = M_NONE;
            end
        endcase
        active_s = (next_state_s == S_FAN_LEAD) || (next_state_s == S_RUN) ||
                   (next_state_s == S_FAN_LAG);
    end

    // State, timer, pointer and registered plant outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            timer_r    <= '0;
            rr_ptr_r   <= '0;
            heat       <= 1'b0;
            fan        <= 1'b0;
            ac         <= 1'b0;
            zone_grant <= '0;
            mode       <= M_NONE;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                timer_r <= '0;
            end else if (timer_r != T_MAX) begin
                timer_r <= timer_r + CW'(1);
            end
            if ((state_r == S_IDLE) && found_s) begin
                rr_ptr_r <= next_ptr_s;
            end
            fan        <= active_s;
            heat       <= (next_state_s == S_RUN) && (next_mode_s == M_HEAT);
            ac         <= (next_state_s == S_RUN) && (next_mode_s == M_COOL);
            zone_grant <= (next_state_s == S_RUN) ? mode_req_s : '0;
            mode       <= active_s ? next_mode_s : M_NONE;
        end
    end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Directed bench for hvac_zone_scheduler: per-cycle expected-output table plus
// a hand-written asynchronous reset sequence and continuous invariant checks.
module tb_hvac_zone_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] heat_req;
    logic [3:0] cool_req;
    logic       heat;
    logic       fan;
    logic       ac;
    logic [3:0] zone_grant;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    hvac_zone_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .heat_req   (heat_req),
        .cool_req   (cool_req),
        .heat       (heat),
        .fan        (fan),
        .ac         (ac),
        .zone_grant (zone_grant),
        .mode       (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {heat, fan, ac, zone_grant[3:0], mode[1:0]} held for n cycles
    typedef struct {
        bit         rst;
        logic [3:0] h;
        logic [3:0] c;
        int         n;
        logic [8:0] exp;
    } rec_t;

    localparam logic [8:0] E_OFF = 9'b0_0_0_0000_00;
    localparam logic [8:0] E_F01 = 9'b0_1_0_0000_01;
    localparam logic [8:0] E_F10 = 9'b0_1_0_0000_10;

    rec_t tbl[$];

    function automatic rec_t mk(bit r, logic [3:0] h, logic [3:0] c, int n, logic [8:0] e);
        rec_t x;
        x.rst = r; x.h = h; x.c = c; x.n = n; x.exp = e;
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        heat_req = 4'b0000;
        cool_req = 4'b0000;
        #2;
        checks++;
        if ({heat, fan, ac, zone_grant, mode} !== E_OFF) begin
            errors++;
            $display("FAIL reset_state: got %b, expected %b",
                     {heat, fan, ac, zone_grant, mode}, E_OFF);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_rec(input int ri, input rec_t r);
        for (int k = 0; k < r.n; k++) begin
            @(negedge clk);
            heat_req = r.h;
            cool_req = r.c;
            @(posedge clk);
            #1;
            checks++;
            if ({heat, fan, ac, zone_grant, mode} !== r.exp) begin
                errors++;
                $display("FAIL rec%0d cyc%0d: got heat=%b fan=%b ac=%b grant=%b mode=%b, expected %b",
                         ri, k, heat, fan, ac, zone_grant, mode, r.exp);
            end
        end
    endtask

    // Plant invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((heat && ac) || ((heat || ac) && !fan) ||
                ((zone_grant != 4'b0000) && !(heat || ac)) || (mode == 2'b11)) begin
                errors++;
                $display("FAIL invariant: heat=%b fan=%b ac=%b grant=%b mode=%b",
                         heat, fan, ac, zone_grant, mode);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        heat_req = 4'b0000;
        cool_req = 4'b0000;

        // cooling run held from IDLE, released after cycle 20
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0010,  2, E_F10));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0010, 18, 9'b0_1_1_0010_10));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  3, E_F10));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  4, E_OFF));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  1, E_OFF));
        // short heat request: MIN_ON keeps heater on 8 cycles
        tbl.push_back(mk(1'b1, 4'b0001, 4'b0000,  2, E_F01));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0000,  2, 9'b1_1_0_0001_01));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  6, 9'b1_1_0_0000_01));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  3, E_F01));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  4, E_OFF));
        // one-cycle request: fan only; requests ignored during lockout
        tbl.push_back(mk(1'b1, 4'b0001, 4'b0000,  1, E_F01));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  1, E_F01));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  3, E_F01));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0000,  4, E_OFF));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0000,  1, E_OFF));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0000,  1, E_F01));
        // competing heat/cool: MAX_RUN preemption and round-robin
        tbl.push_back(mk(1'b1, 4'b0001, 4'b0010,  2, E_F01));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010, 32, 9'b1_1_0_0001_01));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  3, E_F01));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  4, E_OFF));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  1, E_OFF));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  2, E_F10));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010, 32, 9'b0_1_1_0010_10));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  3, E_F10));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  4, E_OFF));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  1, E_OFF));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b0010,  1, E_F01));
        // zone requesting both is served as heat
        tbl.push_back(mk(1'b1, 4'b0100, 4'b0100,  2, E_F01));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b0100, 10, 9'b1_1_0_0100_01));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  3, E_F01));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000,  4, E_OFF));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            run_rec(i, tbl[i]);
        end

        // asynchronous reset in the middle of a heating run
        do_reset();
        run_rec(100, mk(1'b0, 4'b0001, 4'b0000, 2, E_F01));
        run_rec(101, mk(1'b0, 4'b0001, 4'b0000, 3, 9'b1_1_0_0001_01));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({heat, fan, ac, zone_grant, mode} !== E_OFF) begin
            errors++;
            $display("FAIL async_reset: got %b, expected %b",
                     {heat, fan, ac, zone_grant, mode}, E_OFF);
        end
        @(negedge clk);
        reset    = 1'b0;
        heat_req = 4'b0000;
        run_rec(102, mk(1'b0, 4'b0000, 4'b0010, 2, E_F10));
        run_rec(103, mk(1'b0, 4'b0000, 4'b0010, 2, 9'b0_1_1_0010_10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
